// File: rtl/uart_line_assembler_if.sv
// Byte-in / line-out bus of uart_line_assembler: the receiver side drives rx_*,
// the assembler drives the line buffer, its count and the status pulses.
interface uart_line_assembler_if #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned CHARACTER_COUNT = 10
);
    localparam int unsigned CountWidth = $clog2(CHARACTER_COUNT + 2);

    logic [DATA_WIDTH-1:0]                 rx_data;
    logic                                  rx_valid;
    logic [DATA_WIDTH*CHARACTER_COUNT-1:0] sr_data;
    logic                                  frame_valid;
    logic [CountWidth-1:0]                 char_count;
    logic                                  length_err;
    logic                                  timeout_err;

    modport master (
        output rx_data, rx_valid,
        input  sr_data, frame_valid, char_count, length_err, timeout_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output sr_data, frame_valid, char_count, length_err, timeout_err
    );
endinterface

// File: rtl/uart_line_assembler.sv
// Frames CR/LF-terminated lines of exactly CHARACTER_COUNT characters from a UART byte stream.
// Define UART_LINE_ASSEMBLER_LINE_TIMEOUT_EN to abort partial lines after an idle gap.
module uart_line_assembler #(
    parameter int unsigned DATA_WIDTH      = 8,
    parameter int unsigned CHARACTER_COUNT = 10,
    parameter int unsigned TIMEOUT_CYCLES  = 100000
) (
    input logic                  clk,
    input logic                  reset_n,
    uart_line_assembler_if.slave line_bus
);
    localparam int unsigned LineWidth  = DATA_WIDTH * CHARACTER_COUNT;
    localparam int unsigned CountWidth = $clog2(CHARACTER_COUNT + 2);
    localparam logic [CountWidth-1:0] CountFull = CountWidth'(CHARACTER_COUNT);
    localparam logic [CountWidth-1:0] CountOver = CountWidth'(CHARACTER_COUNT + 1);
    localparam logic [DATA_WIDTH-1:0] CharCr    = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] CharLf    = DATA_WIDTH'(8'h0A);

    if (CHARACTER_COUNT < 2 || TIMEOUT_CYCLES < 2) begin : g_bad_params
        $error("CHARACTER_COUNT and TIMEOUT_CYCLES must both be at least 2");
    end

    typedef enum logic [1:0] {StIdle, StCollect, StOverflow} state_e;

    state_e                r_state, w_state_next;
    logic [CountWidth-1:0] r_count, w_count_next;
    logic [LineWidth-1:0]  r_sr;
    logic                  r_frame_valid, w_frame_valid_next;
    logic                  r_length_err, w_length_err_next;
    logic                  w_shift;
    logic                  w_is_term;
    logic                  w_timeout_fire;

    assign w_is_term = (line_bus.rx_data == CharCr) || (line_bus.rx_data == CharLf);

    always_comb begin
        w_state_next       = r_state;
        w_count_next       = r_count;
        w_shift            = 1'b0;
        w_frame_valid_next = 1'b0;
        w_length_err_next  = 1'b0;
        if (line_bus.rx_valid) begin
            case (r_state)
                StIdle: begin
                    // Terminators here are empty lines or the LF of a CR+LF pair.
                    if (!w_is_term) begin
                        w_shift      = 1'b1;
                        w_count_next = CountWidth'(1);
                        w_state_next = StCollect;
                    end
                end
                StCollect: begin
                    if (w_is_term) begin
                        w_frame_valid_next = (r_count == CountFull);
                        w_length_err_next  = (r_count != CountFull);
                        w_count_next       = '0;
                        w_state_next       = StIdle;
                    end else if (r_count == CountFull) begin
                        w_count_next = CountOver;
                        w_state_next = StOverflow;
                    end else begin
                        w_shift      = 1'b1;
                        w_count_next = r_count + CountWidth'(1);
                    end
                end
                StOverflow: begin
                    if (w_is_term) begin
                        w_length_err_next = 1'b1;
                        w_count_next      = '0;
                        w_state_next      = StIdle;
                    end
                end
                default: begin
                    w_count_next = '0;
                    w_state_next = StIdle;
                end
            endcase
        end else if (w_timeout_fire) begin
            w_count_next = '0;
            w_state_next = StIdle;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= StIdle;
            r_count       <= '0;
            r_sr          <= '0;
            r_frame_valid <= 1'b0;
            r_length_err  <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_count       <= w_count_next;
            r_frame_valid <= w_frame_valid_next;
            r_length_err  <= w_length_err_next;
            if (w_shift) begin
                r_sr <= {r_sr[LineWidth-DATA_WIDTH-1:0], line_bus.rx_data};
            end
        end
    end

`ifdef UART_LINE_ASSEMBLER_LINE_TIMEOUT_EN
    localparam int unsigned TimerWidth = $clog2(TIMEOUT_CYCLES);

    logic [TimerWidth-1:0] r_timer;
    logic                  r_timeout_err;

    // A strobe in the expiry cycle wins over the timeout.
    assign w_timeout_fire = (r_state != StIdle) && !line_bus.rx_valid &&
                            (r_timer == TimerWidth'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_timer       <= '0;
            r_timeout_err <= 1'b0;
        end else begin
            r_timeout_err <= w_timeout_fire;
            if (line_bus.rx_valid || w_state_next == StIdle) begin
                r_timer <= '0;
            end else begin
                r_timer <= r_timer + TimerWidth'(1);
            end
        end
    end

    assign line_bus.timeout_err = r_timeout_err;
`else
    assign w_timeout_fire       = 1'b0;
    assign line_bus.timeout_err = 1'b0;
`endif

    assign line_bus.sr_data     = r_sr;
    assign line_bus.frame_valid = r_frame_valid;
    assign line_bus.char_count  = r_count;
    assign line_bus.length_err  = r_length_err;
endmodule
